// File: rtl/axis_tx_arbiter_pkg.sv
// axis_tx_arbiter_pkg: shared FSM state, mode and active-source encodings plus the grant decision
package axis_tx_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GNT0 = 2'd1;
    localparam logic [1:0] ST_GNT1 = 2'd2;

    localparam logic [1:0] MODE_S0   = 2'd0;
    localparam logic [1:0] MODE_S1   = 2'd1;
    localparam logic [1:0] MODE_RR   = 2'd2;
    localparam logic [1:0] MODE_HOLD = 2'd3;

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_S0   = 2'd1;
    localparam logic [1:0] SRC_S1   = 2'd2;

    // Decision taken in IDLE; rr_s1 means s1 wins a tie because s0 finished the last frame
    function automatic logic [1:0] pick_grant(input logic [1:0] mode, input logic v0, input logic v1, input logic rr_s1);
        return (mode == MODE_S0) ? (v0 ? ST_GNT0 : ST_IDLE) :
               (mode == MODE_S1) ? (v1 ? ST_GNT1 : ST_IDLE) :
               (mode == MODE_RR) ? ((v0 && v1) ? (rr_s1 ? ST_GNT1 : ST_GNT0) :
                                    v0 ? ST_GNT0 : v1 ? ST_GNT1 : ST_IDLE) :
               ST_IDLE;
    endfunction

endpackage

// File: rtl/axis_tx_arbiter_if.sv
// axis_tx_arbiter_if: one AXI-Stream channel with producer (master) and consumer (slave) views
interface axis_tx_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int KEEP_W = DATA_W / 8
);
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tlast;
    logic              tuser;
    logic              tready;

    modport master (output tdata, output tkeep, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tkeep, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/axis_skid_buf.sv
// axis_skid_buf: 2-entry registered AXI-Stream stage, full throughput with a registered ready
module axis_skid_buf #(
    parameter int DATA_W = 32,
    parameter int KEEP_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_tdata,
    input  logic [KEEP_W-1:0] i_tkeep,
    input  logic              i_tlast,
    input  logic              i_tuser,
    input  logic              i_tvalid,
    output logic              o_tready,
    output logic [DATA_W-1:0] o_tdata,
    output logic [KEEP_W-1:0] o_tkeep,
    output logic              o_tlast,
    output logic              o_tuser,
    output logic              o_tvalid,
    input  logic              i_tready
);
    localparam int PW = DATA_W + KEEP_W + 2;

    logic [PW-1:0] r_d0;
    logic [PW-1:0] r_d1;
    logic [PW-1:0] w_in;
    logic [1:0]    r_cnt;
    logic          w_push;
    logic          w_pop;

    assign w_in     = {i_tuser, i_tlast, i_tkeep, i_tdata};
    assign o_tready = (r_cnt != 2'd2);
    assign o_tvalid = (r_cnt != 2'd0);
    assign w_push   = i_tvalid & o_tready;
    assign w_pop    = o_tvalid & i_tready;
    assign {o_tuser, o_tlast, o_tkeep, o_tdata} = r_d0;

    // Occupancy: the only state that needs clearing, so reset drops every buffered beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= 2'd0;
        else
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end

    // Payload: head in r_d0, overflow in r_d1; head only moves on pop so it holds while stalled
    always_ff @(posedge clk) begin
        if (w_pop)
            r_d0 <= (r_cnt == 2'd2) ? r_d1 : w_in;
        else if (w_push && r_cnt == 2'd0)
            r_d0 <= w_in;
        if (w_push && !w_pop && r_cnt == 2'd1)
            r_d1 <= w_in;
    end
endmodule

// File: rtl/axis_tx_arbiter.sv
// axis_tx_arbiter: frame-atomic arbiter of PRBS (s0) and loopback (s1) streams onto the MAC TX stream
module axis_tx_arbiter
    import axis_tx_arbiter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int KEEP_W = DATA_W / 8,
    parameter int CNT_W  = 16
) (
    input  logic              tx_axis_usrclk,
    input  logic              reset_in,
    axis_tx_arbiter_if.slave  s0,
    axis_tx_arbiter_if.slave  s1,
    axis_tx_arbiter_if.master m,
    input  logic [1:0]        mode,
    output logic [1:0]        active_src,
    output logic [CNT_W-1:0]  frames_s0,
    output logic [CNT_W-1:0]  frames_s1,
    input  logic              clr_cnt
);
    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_rr_s1;
    logic [CNT_W-1:0]  r_frames_s0;
    logic [CNT_W-1:0]  r_frames_s1;
    logic              w_sel1;
    logic              w_skid_rdy;
    logic              w_in_valid;
    logic [DATA_W-1:0] w_in_data;
    logic [KEEP_W-1:0] w_in_keep;
    logic              w_in_last;
    logic              w_in_user;
    logic              w_last0;
    logic              w_last1;

    assign w_sel1     = (r_state == ST_GNT1);
    assign s0.tready  = (r_state == ST_GNT0) & w_skid_rdy;
    assign s1.tready  = w_sel1 & w_skid_rdy;
    assign w_in_valid = (r_state == ST_GNT0) ? s0.tvalid : w_sel1 ? s1.tvalid : 1'b0;
    assign w_in_data  = w_sel1 ? s1.tdata : s0.tdata;
    assign w_in_keep  = w_sel1 ? s1.tkeep : s0.tkeep;
    assign w_in_last  = w_sel1 ? s1.tlast : s0.tlast;
    assign w_in_user  = w_sel1 ? s1.tuser : s0.tuser;
    assign w_last0    = s0.tvalid & s0.tready & s0.tlast;
    assign w_last1    = s1.tvalid & s1.tready & s1.tlast;
    assign active_src = (r_state == ST_GNT0) ? SRC_S0 : w_sel1 ? SRC_S1 : SRC_NONE;
    assign frames_s0  = r_frames_s0;
    assign frames_s1  = r_frames_s1;

    // Grants are only decided in IDLE, so a mode change never cuts into a frame
    always_comb begin
        w_state_nxt = (r_state == ST_IDLE) ? pick_grant(mode, s0.tvalid, s1.tvalid, r_rr_s1) :
                      (w_last0 | w_last1) ? ST_IDLE : r_state;
    end

    // Grant state and round-robin pointer, which remembers who finished the last frame
    always_ff @(posedge tx_axis_usrclk or posedge reset_in) begin
        if (reset_in) begin
            r_state <= ST_IDLE;
            r_rr_s1 <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_last0)
                r_rr_s1 <= 1'b1;
            else if (w_last1)
                r_rr_s1 <= 1'b0;
        end
    end

    // Completed-frame counters: clear beats a simultaneous increment, saturate at all-ones
    always_ff @(posedge tx_axis_usrclk or posedge reset_in) begin
        if (reset_in) begin
            r_frames_s0 <= '0;
            r_frames_s1 <= '0;
        end else begin
            r_frames_s0 <= clr_cnt ? '0 : (w_last0 && !(&r_frames_s0)) ? r_frames_s0 + CNT_W'(1) : r_frames_s0;
            r_frames_s1 <= clr_cnt ? '0 : (w_last1 && !(&r_frames_s1)) ? r_frames_s1 + CNT_W'(1) : r_frames_s1;
        end
    end

    axis_skid_buf #(.DATA_W(DATA_W), .KEEP_W(KEEP_W)) u_skid (
        .clk      (tx_axis_usrclk),
        .rst      (reset_in),
        .i_tdata  (w_in_data),
        .i_tkeep  (w_in_keep),
        .i_tlast  (w_in_last),
        .i_tuser  (w_in_user),
        .i_tvalid (w_in_valid),
        .o_tready (w_skid_rdy),
        .o_tdata  (m.tdata),
        .o_tkeep  (m.tkeep),
        .o_tlast  (m.tlast),
        .o_tuser  (m.tuser),
        .o_tvalid (m.tvalid),
        .i_tready (m.tready)
    );
endmodule

// File: tb/tb_axis_tx_arbiter.sv
// tb_axis_tx_arbiter: directed and randomized checks of axis_tx_arbiter against a frame-level scoreboard
module tb_axis_tx_arbiter;
    import axis_tx_arbiter_pkg::*;

    localparam int DW = 32;
    localparam int KW = 4;
    localparam int CW = 8;
    localparam logic [CW-1:0] CMAX = '1;

    typedef struct packed {
        logic          user;
        logic          last;
        logic [KW-1:0] keep;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [1:0]    mode;
    logic [1:0]    active_src;
    logic [CW-1:0] frames_s0;
    logic [CW-1:0] frames_s1;
    logic          clr_cnt;

    axis_tx_arbiter_if #(.DATA_W(DW), .KEEP_W(KW)) s0 ();
    axis_tx_arbiter_if #(.DATA_W(DW), .KEEP_W(KW)) s1 ();
    axis_tx_arbiter_if #(.DATA_W(DW), .KEEP_W(KW)) m ();

    axis_tx_arbiter #(.DATA_W(DW), .KEEP_W(KW), .CNT_W(CW)) dut (
        .tx_axis_usrclk (clk),
        .reset_in       (rst),
        .s0             (s0),
        .s1             (s1),
        .m              (m),
        .mode           (mode),
        .active_src     (active_src),
        .frames_s0      (frames_s0),
        .frames_s1      (frames_s1),
        .clr_cnt        (clr_cnt)
    );

    always #5 clk = ~clk;

    int     n_vec = 0;
    int     n_bad = 0;
    beat_t  q0[$];
    beat_t  q1[$];
    beat_t  exp_q[$];
    int     fr_order[$];
    logic   acc0, acc1;
    int     dens0 = 100, dens1 = 100, rdy_mode = 0;
    logic   rand_clr = 1'b0, clr_on_last = 1'b0;
    logic [CW-1:0] c0, c1;
    logic [1:0] open_src;
    logic   prev_stall, prev_acc, prev_mv;
    beat_t  prev_pay;
    int     ncyc = 0, first0 = -1, last0 = -1, n0 = 0, n1 = 0, nout = 0, s0_before_s1 = -1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic beat_t m_beat();
        return {m.tuser, m.tlast, m.tkeep, m.tdata};
    endfunction

    task automatic add_frame(input int src, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = $urandom;
            b.keep = KW'($urandom);
            b.user = 1'($urandom);
            b.last = (i == len - 1);
            if (src == 0) q0.push_back(b);
            else q1.push_back(b);
        end
    endtask

    // Source drivers obey AXIS: a presented beat stays until accepted
    task automatic refresh();
        if (acc0) void'(q0.pop_front());
        if (acc0 || !s0.tvalid) s0.tvalid = (q0.size() > 0) && (int'($urandom_range(0, 99)) < dens0);
        if (q0.size() > 0) {s0.tuser, s0.tlast, s0.tkeep, s0.tdata} = q0[0];
        if (acc1) void'(q1.pop_front());
        if (acc1 || !s1.tvalid) s1.tvalid = (q1.size() > 0) && (int'($urandom_range(0, 99)) < dens1);
        if (q1.size() > 0) {s1.tuser, s1.tlast, s1.tkeep, s1.tdata} = q1[0];
        m.tready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? ($urandom_range(0, 99) < 60) : (ncyc % 3 == 0);
        clr_cnt = rand_clr && ($urandom_range(0, 99) == 0);
        acc0 = 1'b0;
        acc1 = 1'b0;
    endtask

    task automatic cycle();
        beat_t b;
        @(negedge clk);
        chk("frames_s0", frames_s0, c0);
        chk("frames_s1", frames_s1, c1);
        chk("rdy_excl", s0.tready & s1.tready, 0);
        if (prev_stall) begin
            chk("stall_valid", m.tvalid, 1);
            chk("stall_data", m_beat(), prev_pay);
        end
        if (prev_acc && !prev_mv) chk("latency", m.tvalid, 1);
        acc0 = s0.tvalid & s0.tready;
        acc1 = s1.tvalid & s1.tready;
        chk("dual_acc", acc0 & acc1, 0);
        if (m.tvalid & m.tready) begin
            chk("out_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                b = exp_q.pop_front();
                chk("beat", m_beat(), b);
            end
            nout++;
        end
        if (acc0) begin
            chk("active_s0", active_src, SRC_S0);
            chk("interleave_s0", open_src == SRC_S1, 0);
            if (first0 < 0) first0 = ncyc;
            last0 = ncyc;
            n0++;
            exp_q.push_back({s0.tuser, s0.tlast, s0.tkeep, s0.tdata});
            open_src = s0.tlast ? SRC_NONE : SRC_S0;
            if (s0.tlast) fr_order.push_back(1);
        end
        if (acc1) begin
            chk("active_s1", active_src, SRC_S1);
            chk("interleave_s1", open_src == SRC_S0, 0);
            if (s0_before_s1 < 0) s0_before_s1 = n0;
            n1++;
            exp_q.push_back({s1.tuser, s1.tlast, s1.tkeep, s1.tdata});
            open_src = s1.tlast ? SRC_NONE : SRC_S1;
            if (s1.tlast) fr_order.push_back(2);
        end
        if (clr_on_last && acc0 && s0.tlast) begin
            clr_cnt = 1'b1;
            clr_on_last = 1'b0;
        end
        c0 = clr_cnt ? '0 : (acc0 && s0.tlast && c0 != CMAX) ? c0 + 1'b1 : c0;
        c1 = clr_cnt ? '0 : (acc1 && s1.tlast && c1 != CMAX) ? c1 + 1'b1 : c1;
        prev_stall = m.tvalid & ~m.tready;
        prev_pay = m_beat();
        prev_acc = acc0 | acc1;
        prev_mv = m.tvalid;
        ncyc++;
        @(posedge clk);
        #1;
        refresh();
    endtask

    task automatic drain(input int lim);
        int i = 0;
        while (i < lim && (q0.size() + q1.size() + exp_q.size()) != 0) begin
            cycle();
            i++;
        end
        chk("drain", q0.size() + q1.size() + exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_mvalid", m.tvalid, 0);
        chk("rst_rdy", {s0.tready, s1.tready}, 0);
        chk("rst_active", active_src, SRC_NONE);
        chk("rst_frames", {frames_s0, frames_s1}, 0);
        q0.delete(); q1.delete(); exp_q.delete(); fr_order.delete();
        s0.tvalid = 1'b0; s1.tvalid = 1'b0; clr_cnt = 1'b0; clr_on_last = 1'b0;
        acc0 = 1'b0; acc1 = 1'b0; c0 = '0; c1 = '0; open_src = SRC_NONE;
        prev_stall = 1'b0; prev_acc = 1'b0; prev_mv = 1'b0;
        first0 = -1; last0 = -1; n0 = 0; n1 = 0; nout = 0; s0_before_s1 = -1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int i;
        mode = MODE_S0; clr_cnt = 1'b0; m.tready = 1'b1;
        s0.tvalid = 1'b0; s0.tdata = '0; s0.tkeep = '0; s0.tlast = 1'b0; s0.tuser = 1'b0;
        s1.tvalid = 1'b0; s1.tdata = '0; s1.tkeep = '0; s1.tlast = 1'b0; s1.tuser = 1'b0;
        #2;
        // s0-only mode: three 4-beat frames, s1 waiting but never served
        do_reset();
        mode = MODE_S0; rdy_mode = 0;
        repeat (3) add_frame(0, 4);
        add_frame(1, 3);
        refresh();
        i = 0;
        while (i < 200 && (q0.size() + exp_q.size()) != 0) begin
            cycle();
            chk("s1_rdy_idle", s1.tready, 0);
            i++;
        end
        chk("t1_beats", nout, 12);
        chk("t1_frames", frames_s0, 3);
        chk("t1_span", (last0 - first0) <= 13, 1);
        chk("t1_s1_untouched", n1, 0);
        // round-robin with both sources always valid
        do_reset();
        mode = MODE_RR;
        repeat (4) begin add_frame(0, 2); add_frame(1, 2); end
        refresh();
        drain(300);
        chk("rr_nframes", fr_order.size(), 8);
        for (int k = 0; k < fr_order.size(); k++) chk("rr_order", fr_order[k], (k % 2) ? 2 : 1);
        chk("rr_cnt0", frames_s0, 4);
        chk("rr_cnt1", frames_s1, 4);
        // mode switch in the middle of an s0 frame
        do_reset();
        mode = MODE_S0;
        add_frame(0, 5);
        add_frame(1, 3);
        refresh();
        i = 0;
        while (i < 50 && n0 < 2) begin cycle(); i++; end
        mode = MODE_S1;
        drain(200);
        chk("switch_s0_first", s0_before_s1, 5);
        chk("switch_f0", frames_s0, 1);
        chk("switch_f1", frames_s1, 1);
        // back-pressure 1-on/2-off over a 16-beat frame
        do_reset();
        mode = MODE_S0; rdy_mode = 2;
        add_frame(0, 16);
        refresh();
        drain(300);
        chk("stall_beats", nout, 16);
        chk("stall_frames", frames_s0, 1);
        rdy_mode = 0;
        // reset at beat 3 of a 6-beat frame, then a clean frame
        do_reset();
        mode = MODE_S0;
        add_frame(0, 6);
        refresh();
        i = 0;
        while (i < 50 && n0 < 3) begin cycle(); i++; end
        do_reset();
        mode = MODE_S0;
        add_frame(0, 3);
        refresh();
        drain(100);
        chk("post_rst_beats", nout, 3);
        chk("post_rst_frames", frames_s0, 1);
        // saturation, clear, and clear coinciding with an increment
        do_reset();
        mode = MODE_S0;
        repeat (int'(CMAX) + 5) add_frame(0, 1);
        refresh();
        drain(1200);
        chk("sat", frames_s0, CMAX);
        clr_cnt = 1'b1;
        cycle();
        chk("clr", frames_s0, 0);
        repeat (3) add_frame(0, 1);
        clr_on_last = 1'b1;
        refresh();
        drain(100);
        chk("clr_coincide", frames_s0, 2);
        // randomized traffic: modes, densities, back-pressure and clears all vary
        do_reset();
        rand_clr = 1'b1; rdy_mode = 1;
        for (int f = 0; f < 40; f++) begin
            add_frame(0, $urandom_range(1, 6));
            add_frame(1, $urandom_range(1, 6));
        end
        refresh();
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 31) == 0) begin
                dens0 = $urandom_range(20, 100);
                dens1 = $urandom_range(20, 100);
            end
            cycle();
        end
        mode = MODE_RR; rand_clr = 1'b0;
        drain(3000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/axis_tx_arbiter.md
AXIS_TX_ARBITER -- requirements
Module: axis_tx_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, TDATA width of all streams.
REQ-002 SHALL have parameter KEEP_W, default DATA_W/8, TKEEP width.
REQ-003 SHALL have parameter CNT_W, default 16, width of the frame counters.
REQ-004 SHALL have port tx_axis_usrclk  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset_in  in  1  reset, asynchronous assert, active-high.
REQ-006 SHALL have ports s0_tdata/tkeep/tvalid/tlast/tuser  in  DATA_W/KEEP_W/1/1/1  PRBS generator stream; s0_tready  out  1.
REQ-007 SHALL have ports s1_tdata/tkeep/tvalid/tlast/tuser  in  DATA_W/KEEP_W/1/1/1  loopback stream; s1_tready  out  1.
REQ-008 SHALL have ports m_tdata/tkeep/tvalid/tlast/tuser  out  DATA_W/KEEP_W/1/1/1  to the Ethernet MAC TX; m_tready  in  1.
REQ-009 SHALL have port mode  in  2  00 = s0 only, 01 = s1 only, 10 = round-robin, 11 = hold (no new grants).
REQ-010 SHALL have port active_src  out  2  00 = none, 01 = s0, 10 = s1, current grant.
REQ-011 SHALL have ports frames_s0, frames_s1  out  CNT_W each  completed frames forwarded per source.
REQ-012 SHALL have port clr_cnt  in  1  synchronous clear of both frame counters.

Function
REQ-013 SHALL implement FSM states IDLE, GNT0, GNT1.
REQ-014 In IDLE, mode 00 and s0_tvalid -> GNT0; mode 01 and s1_tvalid -> GNT1; mode 11 -> stay IDLE.
REQ-015 Mode 10: if exactly one source is valid, grant it; if both are valid, grant the source not served by the last completed frame (s0 after reset).
REQ-016 GNTx SHALL persist until a beat with s_tlast=1 is accepted from that source (tvalid & tready), then go to IDLE the next cycle.
REQ-017 A mode change mid-frame SHALL NOT affect the current grant; it takes effect at the next IDLE decision.
REQ-018 The ungranted source's tready SHALL be 0; in IDLE both treadys SHALL be 0.
REQ-019 Output SHALL be a 2-entry skid register stage: granted s_tready = 1 while fewer than 2 entries are occupied; m_* driven from the head entry.
REQ-020 Latency SHALL be 1 cycle from input acceptance to m_tvalid; sustained throughput SHALL be 1 beat/cycle when m_tready=1.
REQ-021 m_* SHALL hold stable while m_tvalid=1 and m_tready=0 (AXIS rule); no beat is lost or duplicated.
REQ-022 Grant decision cost: at most 1 idle cycle between a TLAST acceptance and the next frame's first acceptance.
REQ-023 frames_sx SHALL increment on acceptance of that source's TLAST beat, saturating at all-ones.
REQ-024 clr_cnt coincident with an increment SHALL leave the counter at 0.
REQ-025 tdata/tkeep/tuser/tlast SHALL pass through unmodified.

Reset
REQ-026 While reset_in=1: FSM = IDLE, skid buffer empty, m_tvalid=0, s0_tready=s1_tready=0, active_src=00, frames_s0=frames_s1=0, round-robin pointer = s0.
REQ-027 Reset mid-frame SHALL discard buffered beats; the partial frame is not counted.
REQ-028 First grant is possible on the first clock edge after reset_in deasserts.

Structure
REQ-029 A shared package SHALL hold the FSM state enumeration, mode encodings (MODE_S0, MODE_S1, MODE_RR, MODE_HOLD) and active_src encodings.
REQ-030 The skid buffer SHALL be one sub-module, axis_skid_buf, parameterised by DATA_W/KEEP_W.

Verification
REQ-031 mode=00, s0 sends 3 frames of 4 beats, m_tready=1 -> 12 beats on m in order, frames_s0=3, s1_tready always 0.
REQ-032 mode=10, both sources continuously valid with 2-beat frames -> output alternates s0,s1,s0,s1 frame-wise; frames_s0=frames_s1 after 8 frames.
REQ-033 mode switched 00->01 at beat 2 of a 5-beat s0 frame -> all 5 s0 beats emitted, then s1 granted; no interleaving.
REQ-034 m_tready toggled with a 1-on/2-off pattern over a 16-beat frame -> all 16 beats delivered once, m_* stable while stalled.
REQ-035 reset_in asserted at beat 3 of a 6-beat frame -> m_tvalid=0 within the same cycle, counters 0, next frame is forwarded cleanly after release.
REQ-036 frames_s0 preloaded to 0xFFFF by traffic, then one more frame -> stays 0xFFFF; clr_cnt -> 0.
